// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int   RW_BIT   = 0;
  localparam int   BYTE_W   = 8;

endpackage

// File: rtl/i2c_target_if.sv
// Pin and local-logic signals of the I2C target, grouped for the top-level port list.
interface i2c_target_if;
  import i2c_pkg::*;

  logic              scl_i;
  logic              sda_i;
  logic              sda_oe;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_req;
  logic [BYTE_W-1:0] tx_data;
  logic              addressed;
  logic              start_det;
  logic              stop_det;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, addressed, start_det, stop_det
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, addressed, start_det, stop_det
  );

endinterface

// File: rtl/i2c_line_filter.sv
// 2-FF synchronizer plus run-length glitch filter with single-cycle edge strobes.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic [2:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples disagreeing with the filtered level
  always_comb begin
    cnt_d  = 3'd0;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= 3'd0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target engine: bus condition detect, 7-bit address match, byte write/read to local logic.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR       = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input logic          clk,
  input logic          rst,
  i2c_target_if.slave  bus
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .line_i(bus.scl_i),
    .filt_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .line_i(bus.sda_i),
    .filt_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e        state_q, state_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              phase_q, phase_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              addressed_q, addressed_d;
  logic              rx_valid_q, rx_valid_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              tx_req_now;
  logic [BYTE_W-1:0] byte_in;
  logic              scl_edge, start_ev, stop_ev;

  assign byte_in  = {shift_q[BYTE_W-2:0], sda_f};
  // an SDA edge coinciding with an SCL edge is data, not a bus condition
  assign scl_edge = scl_rise | scl_fall;
  assign start_ev = sda_fall & scl_f & ~scl_edge;
  assign stop_ev  = sda_rise & scl_f & ~scl_edge;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    rx_valid_d  = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    tx_req_now  = 1'b0;
    if (start_ev) begin
      state_d     = S_ADDR;
      bitcnt_d    = 4'd0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      start_d     = 1'b1;
    end else if (stop_ev) begin
      state_d     = S_IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_d      = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = 4'd0;
            phase_d  = 1'b0;
            rw_d     = byte_in[RW_BIT];
            state_d  = (byte_in[BYTE_W-1:1] == ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
          end
        end
        // phase_q=0: next fall starts the ACK slot; phase_q=1: next fall ends it
        S_ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d    = ~I2C_ACK;
            addressed_d = 1'b1;
            phase_d     = 1'b1;
          end else if (rw_q) begin
            tx_req_now = 1'b1;
            shift_d    = bus.tx_data;
            sda_oe_d   = ~bus.tx_data[BYTE_W-1];
            bitcnt_d   = 4'd0;
            state_d    = S_RD_DATA;
          end else begin
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
            state_d  = S_WR_DATA;
          end
        end
        S_WR_DATA: if (scl_rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            rx_data_d  = byte_in;
            rx_valid_d = 1'b1;
            bitcnt_d   = 4'd0;
            phase_d    = 1'b0;
            state_d    = S_WR_ACK;
          end
        end
        S_WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = ~I2C_ACK;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = S_WR_DATA;
          end
        end
        S_RD_DATA: if (scl_fall) begin
          if (bitcnt_q == 4'd7) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = S_RD_ACK;
          end else begin
            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            sda_oe_d = ~shift_q[BYTE_W-2];
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_f == I2C_NACK) state_d = S_WAIT_STOP;
            else                   phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            tx_req_now = 1'b1;
            shift_d    = bus.tx_data;
            sda_oe_d   = ~bus.tx_data[BYTE_W-1];
            bitcnt_d   = 4'd0;
            state_d    = S_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= 4'd0;
      rx_data_q   <= '0;
      phase_q     <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_data_q   <= rx_data_d;
      phase_q     <= phase_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      rx_valid_q  <= rx_valid_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_now;
  assign bus.addressed = addressed_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, transaction table plus directed corner sequences.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int FL = 3;
  localparam int Q  = 10;
  localparam int NV = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_target_if bus();

  logic       scl_c = 1'b1;
  logic       sda_c = 1'b1;
  logic [7:0] txq [0:3];
  int         cyc = 0, tx_cnt = 0, last_tx_cyc = 0, last_fall = 0;
  int         rx_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cnt = 0, both_cnt = 0;
  logic [7:0] rx_log [0:63];
  int         tests = 0, fails = 0;

  assign bus.scl_i   = scl_c;
  assign bus.sda_i   = sda_c & ~bus.sda_oe;
  assign bus.tx_data = txq[tx_cnt[1:0]];

  i2c_target #(.ADDR(7'h50), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_req) begin
      tx_cnt      <= tx_cnt + 1;
      last_tx_cyc <= cyc;
    end
  end

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rx_cnt[5:0]] <= bus.rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (bus.start_det) start_cnt <= start_cnt + 1;
    if (bus.stop_det)  stop_cnt  <= stop_cnt + 1;
    if (bus.sda_oe)    oe_cnt    <= oe_cnt + 1;
    if (bus.rx_valid && bus.tx_req) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int glitch, output logic s);
    tick(Q); sda_c = b;
    tick(Q); scl_c = 1'b1;
    tick(Q);
    if (glitch > 0) begin
      scl_c = 1'b0; tick(glitch);
      scl_c = 1'b1; tick(Q);
    end
    s = bus.sda_i;
    tick(Q); scl_c = 1'b0;
    last_fall = cyc;
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == gbit) ? FL - 1 : 0, s);
    send_bit(1'b1, 0, ack);
  endtask

  task automatic read_byte(input logic ackbit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 0, s);
      d[i] = s;
    end
    send_bit(ackbit, 0, s);
  endtask

  task automatic start_c();
    tick(Q); sda_c = 1'b1;
    tick(Q); scl_c = 1'b1;
    tick(Q); sda_c = 1'b0;
    tick(Q); scl_c = 1'b0;
  endtask

  task automatic stop_c();
    tick(Q); sda_c = 1'b0;
    tick(Q); scl_c = 1'b1;
    tick(Q); sda_c = 1'b1;
    tick(Q);
  endtask

  typedef struct {
    logic [7:0] addr;
    int         nbytes;
    logic [7:0] d0, d1;
    logic       exp_aack, exp_dack;
    int         exp_rx, exp_tx;
    logic [7:0] exp_b0, exp_b1;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic       a;
    logic [7:0] rb;
    int rx0, tx0, st0, sp0, oe0, oe1, rel, lat;

    vecs[0] = '{8'hA0, 2, 8'h3C, 8'hFF, I2C_ACK,  I2C_ACK,  2, 0, 8'h3C, 8'hFF};
    vecs[1] = '{8'hA1, 2, 8'h96, 8'h5A, I2C_ACK,  I2C_ACK,  0, 2, 8'h96, 8'h5A};
    vecs[2] = '{8'hA2, 1, 8'h77, 8'h00, I2C_NACK, I2C_NACK, 0, 0, 8'h00, 8'h00};
    vecs[3] = '{8'hA0, 1, 8'h00, 8'h00, I2C_ACK,  I2C_ACK,  1, 0, 8'h00, 8'h00};
    vecs[4] = '{8'hA0, 1, 8'h81, 8'h00, I2C_ACK,  I2C_ACK,  1, 0, 8'h81, 8'h00};
    for (int i = 0; i < 4; i++) txq[i] = 8'h00;

    rst = 1'b1;
    tick(3);
    check("rst_sda_oe",    bus.sda_oe,    1'b0);
    check("rst_rx_data",   bus.rx_data,   8'h00);
    check("rst_rx_valid",  bus.rx_valid,  1'b0);
    check("rst_tx_req",    bus.tx_req,    1'b0);
    check("rst_addressed", bus.addressed, 1'b0);
    check("rst_start_det", bus.start_det, 1'b0);
    check("rst_stop_det",  bus.stop_det,  1'b0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < NV; i++) begin
      txq[tx_cnt[1:0]]      = vecs[i].d0;
      txq[2'(tx_cnt + 1)]   = vecs[i].d1;
      rx0 = rx_cnt; tx0 = tx_cnt; st0 = start_cnt; sp0 = stop_cnt; oe0 = oe_cnt;
      start_c();
      write_byte(vecs[i].addr, -1, a);
      check("addr_ack", a, vecs[i].exp_aack);
      check("addressed_after_ack", bus.addressed, !vecs[i].exp_aack);
      for (int k = 0; k < vecs[i].nbytes; k++) begin
        if (vecs[i].addr[0]) begin
          read_byte(k == vecs[i].nbytes - 1, rb);
          check("rd_byte", rb, (k == 0) ? vecs[i].exp_b0 : vecs[i].exp_b1);
        end else begin
          write_byte((k == 0) ? vecs[i].d0 : vecs[i].d1, -1, a);
          check("data_ack", a, vecs[i].exp_dack);
        end
      end
      oe1 = oe_cnt;
      stop_c();
      tick(2 * Q);
      if (vecs[i].addr[0]) check("drive_after_nack", oe_cnt - oe1, 0);
      if (vecs[i].exp_aack == I2C_NACK) check("drive_unaddressed", oe_cnt - oe0, 0);
      if (vecs[i].exp_rx > 0) check("rx_byte0", rx_log[rx0[5:0]], vecs[i].exp_b0);
      if (vecs[i].exp_rx > 1) check("rx_byte1", rx_log[6'(rx0 + 1)], vecs[i].exp_b1);
      check("rx_valid_count", rx_cnt - rx0, vecs[i].exp_rx);
      check("tx_req_count",   tx_cnt - tx0, vecs[i].exp_tx);
      check("start_count",    start_cnt - st0, 1);
      check("stop_count",     stop_cnt - sp0, 1);
      check("addressed_end",  bus.addressed, 1'b0);
      check("sda_oe_end",     bus.sda_oe, 1'b0);
    end

    // write 0x12, repeated START, read one byte
    rx0 = rx_cnt; tx0 = tx_cnt; st0 = start_cnt; sp0 = stop_cnt;
    txq[tx_cnt[1:0]] = 8'hC3;
    start_c();
    write_byte(8'hA0, -1, a); check("rs_addr_w_ack", a, I2C_ACK);
    write_byte(8'h12, -1, a); check("rs_data_ack", a, I2C_ACK);
    start_c();
    write_byte(8'hA1, -1, a); check("rs_addr_r_ack", a, I2C_ACK);
    rel = last_fall;
    read_byte(1'b1, rb);
    check("rs_rd_byte", rb, 8'hC3);
    lat = last_tx_cyc - rel;
    check("rs_tx_req_latency", (lat >= FL + 2) && (lat <= FL + 3), 1'b1);
    stop_c();
    tick(2 * Q);
    check("rs_start_count", start_cnt - st0, 2);
    check("rs_stop_count",  stop_cnt - sp0, 1);
    check("rs_rx_data",     bus.rx_data, 8'h12);
    check("rs_rx_count",    rx_cnt - rx0, 1);
    check("rs_tx_count",    tx_cnt - tx0, 1);

    // SCL glitch shorter than the filter during bit 4 of a data byte
    rx0 = rx_cnt;
    start_c();
    write_byte(8'hA0, -1, a);
    write_byte(8'hC5, 4, a);
    check("glitch_ack", a, I2C_ACK);
    stop_c();
    tick(2 * Q);
    check("glitch_rx_count", rx_cnt - rx0, 1);
    check("glitch_rx_data",  bus.rx_data, 8'hC5);

    // STOP after four data bits
    rx0 = rx_cnt; sp0 = stop_cnt;
    start_c();
    write_byte(8'hA0, -1, a);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0, a);
    stop_c();
    tick(2 * Q);
    check("midstop_rx_count",  rx_cnt - rx0, 0);
    check("midstop_stop",      stop_cnt - sp0, 1);
    check("midstop_sda_oe",    bus.sda_oe, 1'b0);
    check("midstop_addressed", bus.addressed, 1'b0);

    // reset while the address ACK is being driven
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(rb[0] ^ rb[0] ^ 8'hA0 >> i, 0, a);
    tick(Q);
    check("ack_drive_before_rst", bus.sda_oe, 1'b1);
    sda_c = 1'b1;
    rst = 1'b1;
    tick(1);
    check("rst_mid_sda_oe",    bus.sda_oe,    1'b0);
    check("rst_mid_addressed", bus.addressed, 1'b0);
    check("rst_mid_rx_valid",  bus.rx_valid,  1'b0);
    check("rst_mid_tx_req",    bus.tx_req,    1'b0);
    check("rst_mid_start_det", bus.start_det, 1'b0);
    check("rst_mid_stop_det",  bus.stop_det,  1'b0);
    rst = 1'b0;
    scl_c = 1'b1;
    tick(2 * Q);
    rx0 = rx_cnt;
    start_c();
    write_byte(8'hA0, -1, a); check("post_rst_addr_ack", a, I2C_ACK);
    write_byte(8'h5E, -1, a); check("post_rst_data_ack", a, I2C_ACK);
    stop_c();
    tick(2 * Q);
    check("post_rst_rx_count", rx_cnt - rx0, 1);
    check("post_rst_rx_data",  bus.rx_data, 8'h5E);

    check("rx_valid_tx_req_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
